// File: rtl/demux_1_4_32_buf_if.sv
// Handshake bundle for the 1-to-4 result demux: one tagged input stream and
// four independent buffered output channels.
interface demux_1_4_32_buf_if #(
   parameter int N     = 32,
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            in_valid;
   logic            in_ready;
   logic [N-1:0]    in_data;
   logic [1:0]      in_sel;
   logic [3:0]      out_valid;
   logic [3:0]      out_ready;
   logic [4*N-1:0]  out_data;
   logic [4*CW-1:0] out_count;

   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data, out_count
   );

   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data, out_count
   );
endinterface

// File: rtl/demux_1_4_32_buf.sv
// Registered 1-to-4 demux: each tagged input word lands in one of four
// per-destination FIFOs, and each FIFO drains independently of the others.
module demux_1_4_32_buf #(
   parameter int N     = 32,
   parameter int DEPTH = 2
) (
   input logic               clk,
   input logic               rst_n,
   demux_1_4_32_buf_if.slave bus
);
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;
   localparam int NCH = 4;

   logic [N-1:0]  mem_q     [NCH][DEPTH];
   logic [N-1:0]  mem_d     [NCH][DEPTH];
   logic [PW-1:0] wr_ptr_q  [NCH];
   logic [PW-1:0] wr_ptr_d  [NCH];
   logic [PW-1:0] rd_ptr_q  [NCH];
   logic [PW-1:0] rd_ptr_d  [NCH];
   logic [CW-1:0] count_q   [NCH];
   logic [CW-1:0] count_d   [NCH];

   logic [NCH-1:0] full;
   logic [NCH-1:0] empty;
   logic [NCH-1:0] push;
   logic [NCH-1:0] pop;
   logic           in_ready;

   logic [NCH-1:0]    out_valid;
   logic [NCH*N-1:0]  out_data;
   logic [NCH*CW-1:0] out_count;

   always_comb begin
      full  = '0;
      empty = '0;
      for (int k = 0; k < NCH; k++) begin
         full[k]  = (count_q[k] == CW'(DEPTH));
         empty[k] = (count_q[k] == '0);
      end
   end

   // Readiness depends only on the selected channel's registered fill level,
   // so a pop on a full channel never opens a same-cycle push.
   assign in_ready = !full[bus.in_sel];

   always_comb begin
      push = '0;
      pop  = '0;
      for (int k = 0; k < NCH; k++) begin
         push[k] = bus.in_valid && in_ready && (bus.in_sel == 2'(k));
         pop[k]  = !empty[k] && bus.out_ready[k];
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      for (int k = 0; k < NCH; k++) begin
         if (push[k]) begin
            mem_d[k][wr_ptr_q[k]] = bus.in_data;
            wr_ptr_d[k]           = wr_ptr_q[k] + PW'(1);
         end
         if (pop[k]) begin
            rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
         end
         case ({push[k], pop[k]})
            2'b10:   count_d[k] = count_q[k] + CW'(1);
            2'b01:   count_d[k] = count_q[k] - CW'(1);
            default: count_d[k] = count_q[k];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NCH; k++) begin
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
            count_q[k]  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
               mem_q[k][e] <= '0;
            end
         end
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Heads come straight from storage, never from in_data.
   always_comb begin
      out_valid = '0;
      out_data  = '0;
      out_count = '0;
      for (int k = 0; k < NCH; k++) begin
         out_valid[k]           = !empty[k];
         out_data[k*N +: N]     = mem_q[k][rd_ptr_q[k]];
         out_count[k*CW +: CW]  = count_q[k];
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data;
   assign bus.out_count = out_count;
endmodule

// File: tb/tb_demux_1_4_32_buf.sv
// Directed bench for demux_1_4_32_buf: a per-channel scoreboard filled at
// push time and drained by a monitor on every output handshake.
module tb_demux_1_4_32_buf;
   logic clk;
   logic rst_n;

   demux_1_4_32_buf_if #(.N(32), .DEPTH(2)) bif ();

   demux_1_4_32_buf #(.N(32), .DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [4][$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] head(input int k);
      return bif.out_data[k*32 +: 32];
   endfunction

   function automatic logic [31:0] cnt(input int k);
      return {30'd0, bif.out_count[k*2 +: 2]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] s, input logic [31:0] d);
      int tries;
      bif.in_valid = 1'b1;
      bif.in_sel   = s;
      bif.in_data  = d;
      #1;
      tries = 0;
      while (!bif.in_ready && tries < 50) begin
         step();
         tries++;
      end
      if (!bif.in_ready) begin
         chk("push_timeout", {31'd0, bif.in_ready}, 32'd1);
      end else begin
         exp_q[s].push_back(d);
         step();
      end
      bif.in_valid = 1'b0;
   endtask

   // Monitor: every accepted head must match the oldest expected word.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 4; k++) begin
            if (bif.out_valid[k] && bif.out_ready[k]) begin
               checks++;
               if (exp_q[k].size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_ch%0d actual=%h required=none", k, head(k));
               end else begin
                  logic [31:0] e;
                  e = exp_q[k].pop_front();
                  if (head(k) !== e) begin
                     errors++;
                     $display("FAIL data_ch%0d actual=%h required=%h", k, head(k), e);
                  end
               end
            end
         end
      end
   end

   initial begin
      rst_n         = 1'b0;
      bif.in_valid  = 1'b0;
      bif.in_sel    = 2'd0;
      bif.in_data   = 32'd0;
      bif.out_ready = 4'b0000;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("rst_out_valid", {28'd0, bif.out_valid}, 32'd0);
      chk("rst_out_data_lo", bif.out_data[63:0] == 64'd0 ? 32'd0 : 32'd1, 32'd0);
      chk("rst_out_data_hi", bif.out_data[127:64] == 64'd0 ? 32'd0 : 32'd1, 32'd0);
      chk("rst_out_count", {24'd0, bif.out_count}, 32'd0);
      for (int s = 0; s < 4; s++) begin
         bif.in_sel = 2'(s);
         #1;
         chk($sformatf("rst_in_ready_sel%0d", s), {31'd0, bif.in_ready}, 32'd1);
      end
      step();

      // Single route to channel 2
      push(2'd2, 32'hDEADBEEF);
      chk("single_valid", {28'd0, bif.out_valid}, 32'h4);
      chk("single_data", head(2), 32'hDEADBEEF);
      chk("single_count", cnt(2), 32'd1);
      bif.out_ready = 4'b0100;
      step();
      bif.out_ready = 4'b0000;
      chk("single_drained", {28'd0, bif.out_valid}, 32'd0);

      // Fill channel 1 and check backpressure
      push(2'd1, 32'h1);
      push(2'd1, 32'h2);
      chk("fill_count1", cnt(1), 32'd2);
      bif.in_sel = 2'd1;
      #1;
      chk("fill_ready_sel1", {31'd0, bif.in_ready}, 32'd0);
      bif.in_sel = 2'd0;
      #1;
      chk("fill_ready_sel0", {31'd0, bif.in_ready}, 32'd1);
      bif.in_sel    = 2'd1;
      bif.out_ready = 4'b0010;
      #1;
      chk("full_ready_ignores_out_ready", {31'd0, bif.in_ready}, 32'd0);
      step();
      chk("fill_count_after_pop", cnt(1), 32'd1);
      chk("fill_ready_restored", {31'd0, bif.in_ready}, 32'd1);
      chk("fill_head_second", head(1), 32'h2);
      step();
      bif.out_ready = 4'b0000;
      chk("fill_drained", {31'd0, bif.out_valid[1]}, 32'd0);

      // Concurrent push and pop on channel 3
      push(2'd3, 32'hA);
      chk("conc_count_before", cnt(3), 32'd1);
      bif.out_ready = 4'b1000;
      bif.in_valid  = 1'b1;
      bif.in_sel    = 2'd3;
      bif.in_data   = 32'hB;
      #1;
      chk("conc_ready", {31'd0, bif.in_ready}, 32'd1);
      exp_q[3].push_back(32'hB);
      step();
      bif.in_valid  = 1'b0;
      bif.out_ready = 4'b0000;
      chk("conc_count_after", cnt(3), 32'd1);
      chk("conc_head", head(3), 32'hB);
      bif.out_ready = 4'b1000;
      step();
      bif.out_ready = 4'b0000;
      chk("conc_drained", {31'd0, bif.out_valid[3]}, 32'd0);

      // Independence: channel 0 full and stalled, others stream
      push(2'd0, 32'hC0);
      push(2'd0, 32'hC1);
      bif.out_ready = 4'b1110;
      push(2'd1, 32'h10);
      push(2'd2, 32'h11);
      push(2'd3, 32'h12);
      push(2'd1, 32'h13);
      step();
      step();
      chk("indep_valid", {28'd0, bif.out_valid}, 32'h1);
      chk("indep_head0", head(0), 32'hC0);
      chk("indep_count0", cnt(0), 32'd2);
      chk("indep_delivered", exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 32'd0);
      bif.out_ready = 4'b0000;

      // Full channel popped this cycle must not accept a push until next cycle
      bif.in_valid  = 1'b1;
      bif.in_sel    = 2'd0;
      bif.in_data   = 32'hC2;
      bif.out_ready = 4'b0001;
      #1;
      chk("fullpop_ready_same", {31'd0, bif.in_ready}, 32'd0);
      step();
      chk("fullpop_count", cnt(0), 32'd1);
      chk("fullpop_ready_next", {31'd0, bif.in_ready}, 32'd1);
      chk("fullpop_head", head(0), 32'hC1);
      exp_q[0].push_back(32'hC2);
      step();
      bif.in_valid = 1'b0;
      chk("fullpop_count_pp", cnt(0), 32'd1);
      chk("fullpop_head_pp", head(0), 32'hC2);
      step();
      bif.out_ready = 4'b0000;
      chk("fullpop_drained", {28'd0, bif.out_valid}, 32'd0);

      // Reset mid-operation drops buffered words
      push(2'd2, 32'h20);
      push(2'd2, 32'h21);
      chk("midrst_count_before", cnt(2), 32'd2);
      rst_n = 1'b0;
      #2;
      chk("midrst_valid_async", {28'd0, bif.out_valid}, 32'd0);
      chk("midrst_count_async", {24'd0, bif.out_count}, 32'd0);
      for (int k = 0; k < 4; k++) exp_q[k].delete();
      #3 rst_n = 1'b1;
      bif.out_ready = 4'b1111;
      repeat (3) step();
      chk("midrst_valid_after", {28'd0, bif.out_valid}, 32'd0);
      chk("midrst_data_after", bif.out_data[95:64], 32'd0);
      bif.out_ready = 4'b0000;

      chk("scoreboard_empty",
          exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/demux_1_4_32_buf.md
Name: demux_1_4_32_buf

Overview:
- Registered 1-to-4 demultiplexer with a valid/ready handshake on every port; the distributing counterpart of the datapath select muxes.
- One 32-bit result stream, tagged with a 2-bit destination select, is steered into one of four per-destination FIFOs.
- Each destination drains its FIFO independently, so a stalled consumer never blocks the other three.
- Sits between the result/writeback stage and up to four downstream consumers (register-file write port, PC logic, memory write data, debug tap).

Parameters:
- N, 32, data width in bits.
- DEPTH, 2, entries per channel FIFO; power of two, >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word on in_data/in_sel.
- in_ready  output  1  selected channel can accept this cycle.
- in_data  input  N  word to route.
- in_sel  input  2  destination channel, 0..3.
- out_valid  output  4  bit k: channel k head entry is valid.
- out_ready  input  4  bit k: consumer k accepts the head this cycle.
- out_data  output  4*N  channel k head at bits [k*N +: N].
- out_count  output  4*($clog2(DEPTH)+1)  occupancy of channel k at slice k, each field ($clog2(DEPTH)+1) bits wide.

Behaviour:
- Reset (rst_n=0, asynchronous): every FIFO is emptied and read/write pointers are zeroed. out_valid=0, out_count=0, storage cleared so out_data=0. in_ready reflects the empty FIFOs (1) once rst_n=1. Reset asserted mid-transfer drops all buffered and in-flight words; no partial state survives.
- Per-channel FIFO: DEPTH entries, with a write pointer, a read pointer and an occupancy count. Pointers wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0).
- in_ready = !full[in_sel]. It is combinational from in_sel and registered state only; there is no path from out_ready. It is valid whether or not in_valid is asserted.
- Push: when in_valid & in_ready at a rising edge, in_data is written to FIFO in_sel and that channel's count increments. Only one channel is written per cycle.
- Pop: when out_valid[k] & out_ready[k] at a rising edge, channel k advances its read pointer and decrements its count. Any number of channels may pop in the same cycle.
- Outputs: out_valid[k] = !empty[k]. out_data slice k = storage[k][rd_ptr[k]], read from registers with no combinational path from in_data.
- Latency: a word accepted at edge t is visible on out_valid/out_data of its channel immediately after edge t, i.e. 1 cycle, when the channel was empty.
- Simultaneous push and pop on the same channel: both take effect and count is unchanged. This requires count >= 1, because a pop needs out_valid.
- Full channel: in_ready=0 when that channel is selected. A pop on that channel in the same cycle does NOT enable a same-cycle push; the push succeeds the following cycle.
- Ordering: strict FIFO order within a channel. No ordering guarantee across channels.
- in_sel is sampled only when in_valid & in_ready. in_data and in_sel may change freely when no transfer occurs.
- Data stability: while out_valid[k]=1 and out_ready[k]=0, out_data slice k and out_valid[k] hold stable.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then released -> out_valid=4'b0000, out_data all 0, out_count 0, in_ready=1 for every in_sel.
- Single route: push 32'hDEADBEEF with sel=2 at edge t -> after t, out_valid=4'b0100 and slice 2=32'hDEADBEEF; out_ready[2]=1 at edge t+1 -> out_valid=0.
- Fill and backpressure: out_ready=0; push 32'h1, 32'h2 to ch1 -> count1=2, in_ready=0 for sel=1 but 1 for sel=0. Then assert out_ready[1] -> ch1 pops 32'h1 and then 32'h2, in order; in_ready returns to 1 one cycle after the first pop.
- Concurrent push/pop: ch3 holds 32'hA; push 32'hB to ch3 while popping -> count3 stays 1 and head becomes 32'hB.
- Independence: ch0 full and stalled; stream 32'h10..32'h13 to ch1/2/3 with ready high -> all delivered; ch0 head unchanged.
- Reset mid-operation: ch2 holds 2 entries; pulse rst_n low for half a cycle -> out_valid drops to 0 asynchronously, counts are 0, and the previously buffered data never appears.
